// File: rtl/hex_scan_ctrl.sv
// Channel scanner feeding the single-digit hexdriver: picks one enabled nibble at a time,
// rotating on a dwell timer (auto) or stepping on a debounced-by-sync pushbutton (hold).
module hex_scan_ctrl #(
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned TW    = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ch_data_i,
    input  logic [3:0]  ch_en_i,
    input  logic        hold_sw_i,
    input  logic        step_i,
    output logic [3:0]  digit_out_o,
    output logic [1:0]  chan_idx_o,
    output logic        blank_o,
    output logic        advance_o
);

    localparam logic [TW-1:0] TIMER_LAST = TW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AUTO = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      chan_q, chan_d;
    logic [3:0]      digit_q, digit_d;
    logic            blank_q, blank_d;
    logic            adv_q, adv_d;
    logic            s1_q, s2_q, s3_q;

    logic            step_rise;
    logic            cur_en;
    logic            mode_change;
    logic [1:0]      next_idx;
    logic [1:0]      low_idx;

    // First enabled channel after idx, wrapping round to idx itself last.
    function automatic logic [1:0] next_en(input logic [1:0] idx, input logic [3:0] en);
        logic [1:0] r;
        logic [1:0] cand;
        r = idx;
        for (int i = 4; i >= 1; i--) begin
            cand = idx + 2'(i);
            if (en[cand]) r = cand;
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest_en(input logic [3:0] en);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign step_rise   = s2_q & ~s3_q;
    assign cur_en      = ch_en_i[chan_q];
    assign next_idx    = next_en(chan_q, ch_en_i);
    assign low_idx     = lowest_en(ch_en_i);
    assign mode_change = ((state_q == AUTO) && hold_sw_i) || ((state_q == HOLD) && !hold_sw_i);

    // State and output registers, plus the step synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            chan_q  <= 2'd0;
            digit_q <= 4'd0;
            blank_q <= 1'b1;
            adv_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            chan_q  <= chan_d;
            digit_q <= digit_d;
            blank_q <= blank_d;
            adv_q   <= adv_d;
            s1_q    <= step_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    // Next-state: a disabled current channel outranks a mode change.
    always_comb begin
        state_d = state_q;
        if (ch_en_i == 4'd0) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = hold_sw_i ? HOLD : AUTO;
                AUTO:    if (cur_en && hold_sw_i) state_d = HOLD;
                HOLD:    if (cur_en && !hold_sw_i) state_d = AUTO;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and dwell timer.
    always_comb begin
        chan_d  = chan_q;
        timer_d = timer_q;
        adv_d   = 1'b0;
        blank_d = 1'b0;
        digit_d = digit_q;
        if (ch_en_i == 4'd0) begin
            blank_d = 1'b1;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    chan_d  = low_idx;
                    timer_d = '0;
                    adv_d   = 1'b1;
                end
                AUTO, HOLD: begin
                    if (!cur_en || (!mode_change && step_rise)) begin
                        chan_d  = next_idx;
                        timer_d = '0;
                        adv_d   = 1'b1;
                    end else if (mode_change || (state_q == HOLD)) begin
                        timer_d = '0;
                    end else if (timer_q >= TIMER_LAST) begin
                        chan_d  = next_idx;
                        timer_d = '0;
                        adv_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    timer_d = '0;
                end
            endcase
            digit_d = ch_data_i[{chan_d, 2'b00} +: 4];
        end
    end

    assign digit_out_o = digit_q;
    assign chan_idx_o  = chan_q;
    assign blank_o     = blank_q;
    assign advance_o   = adv_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with a short dwell of 4 cycles.
module tb_hex_scan_ctrl;

    localparam int unsigned DWELL = 4;
    localparam int unsigned TW    = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ch_data;
    logic [3:0]  ch_en;
    logic        hold_sw;
    logic        step;
    logic [3:0]  digit_out;
    logic [1:0]  chan_idx;
    logic        blank;
    logic        advance;

    int checks   = 0;
    int failures = 0;

    hex_scan_ctrl #(.DWELL(DWELL), .TW(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data_i   (ch_data),
        .ch_en_i     (ch_en),
        .hold_sw_i   (hold_sw),
        .step_i      (step),
        .digit_out_o (digit_out),
        .chan_idx_o  (chan_idx),
        .blank_o     (blank),
        .advance_o   (advance)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over one edge with the given inputs, then releases it between edges.
    task automatic do_reset(input logic [3:0] en, input logic hold);
        rst_n   = 1'b0;
        ch_en   = en;
        hold_sw = hold;
        step    = 1'b0;
        ch_data = 16'h4321;
        tick();
        rst_n = 1'b1;
    endtask

    // After reset release with all channels on in auto mode: 0 shown first, then 1,2,3,0 every 4 cycles.
    task automatic run_rotation(input string tag);
        int advs;
        logic [1:0] exp_ch;
        tick();
        check({tag, "_start_chan"}, chan_idx, 0);
        check({tag, "_start_digit"}, digit_out, 1);
        check({tag, "_start_adv"}, advance, 1);
        check({tag, "_start_blank"}, blank, 0);
        for (int s = 1; s <= 4; s++) begin
            advs = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                advs += int'(advance);
            end
            check({tag, "_dwell_no_adv"}, advs, 0);
            tick();
            exp_ch = 2'(s);
            check({tag, "_rot_chan"}, chan_idx, exp_ch);
            check({tag, "_rot_digit"}, digit_out, 32'(exp_ch) + 1);
            check({tag, "_rot_adv"}, advance, 1);
        end
    endtask

    initial begin
        int advs;

        // 1: reset values, then auto rotation over all four channels
        do_reset(4'b1111, 1'b0);
        check("rst_chan", chan_idx, 0);
        check("rst_digit", digit_out, 0);
        check("rst_blank", blank, 1);
        check("rst_adv", advance, 0);
        run_rotation("s1");

        // 2: sparse enables alternate 1,3; dropping channel 1 jumps straight to 3
        do_reset(4'b1010, 1'b0);
        tick();
        check("s2_first_chan", chan_idx, 1);
        check("s2_first_digit", digit_out, 2);
        for (int i = 0; i < 4; i++) tick();
        check("s2_chan3", chan_idx, 3);
        check("s2_digit4", digit_out, 4);
        for (int i = 0; i < 4; i++) tick();
        check("s2_chan1", chan_idx, 1);
        ch_en = 4'b1000;
        tick();
        check("s2_drop_chan", chan_idx, 3);
        check("s2_drop_adv", advance, 1);
        advs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            advs += int'(advance);
        end
        check("s2_restart_no_adv", advs, 0);
        tick();
        check("s2_single_adv", advance, 1);
        check("s2_single_chan", chan_idx, 3);

        // 3: manual stepping with a synchronised pushbutton
        do_reset(4'b1111, 1'b1);
        tick();
        check("s3_hold_start", chan_idx, 0);
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            for (int i = 0; i < 3; i++) tick();
            step = 1'b0;
            for (int i = 0; i < 3; i++) tick();
        end
        check("s3_at_chan2", chan_idx, 2);
        advs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            advs += int'(advance);
        end
        check("s3_hold_still_chan", chan_idx, 2);
        check("s3_hold_still_adv", advs, 0);
        step = 1'b1;
        tick();
        check("s3_k_chan", chan_idx, 2);
        tick();
        check("s3_k1_chan", chan_idx, 2);
        check("s3_k1_adv", advance, 0);
        tick();
        check("s3_k2_chan", chan_idx, 3);
        check("s3_k2_adv", advance, 1);
        step = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        advs = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            advs += int'(advance);
        end
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            advs += int'(advance);
        end
        check("s3_long_press_advs", advs, 1);
        check("s3_long_press_chan", chan_idx, 0);

        // 4: all channels off blanks the display, a single channel revives it
        do_reset(4'b1111, 1'b0);
        tick();
        tick();
        ch_en = 4'b0000;
        tick();
        check("s4_blank_on", blank, 1);
        check("s4_blank_adv", advance, 0);
        tick();
        check("s4_blank_stays", blank, 1);
        ch_en = 4'b0100;
        tick();
        check("s4_wake_chan", chan_idx, 2);
        check("s4_wake_blank", blank, 0);
        check("s4_wake_adv", advance, 1);
        check("s4_wake_digit", digit_out, 3);

        // 5: step rise on the timer-expiry cycle gives one advance and restarts the dwell
        do_reset(4'b1111, 1'b0);
        tick();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("s5_pre_chan", chan_idx, 0);
        tick();
        check("s5_coincide_chan", chan_idx, 1);
        check("s5_coincide_adv", advance, 1);
        advs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            advs += int'(advance);
        end
        check("s5_no_double", advs, 0);
        tick();
        check("s5_next_chan", chan_idx, 2);

        // 6: short asynchronous reset mid-rotation
        do_reset(4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("s6_pre_chan", chan_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_chan", chan_idx, 0);
        check("s6_async_digit", digit_out, 0);
        check("s6_async_blank", blank, 1);
        check("s6_async_adv", advance, 0);
        #1 rst_n = 1'b1;
        run_rotation("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
Time-multiplexes four 4-bit value channels onto the single-digit hexdriver path (BCD split plus two 7-segment decoders). It selects one enabled channel at a time, either rotating automatically on a dwell timer or stepping manually from a pushbutton. It presents the selected nibble plus the channel index, so a second decoder can show which channel is on screen. It sits between the datapath sources and the hexdriver; it does not decode segments itself.

Parameters:
DWELL, 50000000, clock cycles each channel is shown in auto mode (1 s at 50 MHz); legal range 2 to 2^TW-1.
TW, 26, width of the dwell timer in bits.

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
ch_data  in  16  channel nibbles; channel n is bits [4n+3:4n]
ch_en  in  4  per-channel enable; disabled channels are skipped
hold_sw  in  1  1 = manual (HOLD) mode, 0 = auto rotate; level, treated as synchronous
step  in  1  raw pushbutton, active-high, asynchronous to clk
digit_out  out  4  selected nibble, to the hexdriver 4-bit input
chan_idx  out  2  index of the channel currently shown
blank  out  1  1 = no channel enabled; downstream shows nothing
advance  out  1  one-cycle pulse on every channel change

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, chan_idx=0, digit_out=0, blank=1, advance=0.
  - Dwell timer=0; step synchroniser and edge registers=0.
- Step input handling:
  - 2-flop synchroniser (s1, s2) plus a previous-value register s3.
  - step_rise = s2 & ~s3.
  - If step is first sampled high at edge k, chan_idx changes at edge k+2.
- next_en(idx): first enabled channel searching idx+1, idx+2, idx+3, idx (mod 4). If the current channel is the only enabled one, next_en returns the same index.
- States:
  - IDLE:
    - blank=1; digit_out holds its last value.
    - Leaves IDLE when ch_en != 0. Next cycle, chan_idx = lowest enabled index, timer=0, advance=1.
    - Goes to HOLD if hold_sw=1, otherwise AUTO.
  - AUTO:
    - Timer increments every cycle.
    - When timer==DWELL-1: chan_idx <= next_en(chan_idx), timer <= 0, advance=1.
    - With a single enabled channel, chan_idx is unchanged but advance still pulses.
    - step_rise advances immediately (same rule) and clears the timer.
    - hold_sw=1 moves to HOLD with timer cleared, and no advance that cycle.
  - HOLD:
    - Timer frozen at 0.
    - step_rise: chan_idx <= next_en(chan_idx), advance=1.
    - hold_sw=0 moves to AUTO with timer=0.
- Priority each cycle, highest first:
  1. ch_en==0 -> IDLE (blank=1, advance=0).
  2. Current channel disabled -> chan_idx <= next_en(chan_idx), timer=0, advance=1. Any step_rise that cycle is consumed.
  3. Mode change.
  4. step_rise.
  5. Timer expiry.
  - Timer expiry coinciding with step_rise produces exactly one advance.
- Outputs:
  - digit_out is registered: digit_out <= ch_data nibble of the next-cycle chan_idx.
  - A ch_data change appears on digit_out after 1 cycle.
  - A channel change updates chan_idx and digit_out on the same edge.
  - blank=0 in AUTO and HOLD.
  - All outputs are registered; no combinational path from input to output.
- Timer arithmetic: unsigned TW bits; never wraps past DWELL-1.

Test Plan:
1. DWELL=4, ch_en=1111, hold_sw=0, ch_data=16'h4321, release reset -> one cycle later chan_idx=0, digit_out=1, advance=1; then chan_idx steps 1,2,3,0 every 4 cycles with digit_out 2,3,4,1; advance pulses exactly once per step.
2. ch_en=1010, auto mode -> chan_idx alternates 1,3,1,3 and never shows 0 or 2. Drop ch_en to 1000 while chan_idx=1 -> chan_idx=3 on the next edge, timer restarts.
3. hold_sw=1, ch_en=1111, chan_idx=2 -> no change for 20 cycles. Pulse step high for 3 cycles, sampled at edge k -> chan_idx=3 at edge k+2 and advance=1 once. Hold step high for 10 cycles -> still a single advance.
4. ch_en -> 0000 during AUTO -> blank=1 next cycle. ch_en -> 0100 -> chan_idx=2, blank=0, advance=1 one cycle later.
5. AUTO with step_rise landing on the cycle timer==DWELL-1 -> a single advance by one channel, timer=0.
6. Assert rst_n low for a partial cycle mid-rotation -> all outputs return to reset values immediately, without waiting for a clk edge. After release, the bench repeats scenario 1's sequence from chan_idx=0.
